// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (parity modes, FSM encoding, frame sizing) for the tx/rx pair.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Serial bit slots in one frame: start + data + optional parity + stop(s).
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_baud.sv
// Purpose: bit-period timer; flags the last sclk cycle of every serial bit while enabled.
// Latency: bit_tick asserts CLK_DIV cycles after en rises, then every CLK_DIV cycles.
// Backpressure: none; counter is held at zero whenever en is low.
// Ports: sclk/rst_n clock and async active-low reset, en run enable, bit_tick end-of-bit flag.
module uart_baud_tick #(
    parameter int CLK_DIV = 5208
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic en,
    output logic bit_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d    = '0;
        bit_tick = 1'b0;
        if (en) begin
            bit_tick = (cnt_q == CNT_LAST);
            cnt_d    = bit_tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Purpose: parametrised UART transmitter (5..8 data bits, none/odd/even parity, 1..2 stop bits), LSB first.
// Latency: tx drops on the accept edge; tx_done pulses one cycle after the last stop bit ends.
// Backpressure: tx_ready is high only in IDLE; tx_valid while a frame is in flight is ignored.
// Ports: sclk, rst_n (async active-low); tx_valid/tx_ready/tx_data byte handshake;
//        tx serial line (registered, idle high); tx_busy frame in progress; tx_done end-of-frame pulse.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_cfg: illegal parameter set");
    end

    // One index counter serves both data bits and stop bits.
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    logic                 bit_tick;
    logic [IDX_W-1:0]     idx_inc;
    logic                 par_bit;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .en       (state_q != ST_IDLE),
        .bit_tick (bit_tick)
    );

    assign idx_inc = idx_q + IDX_W'(1);
    assign par_bit = (PARITY == PARITY_EVEN) ? ^data_q : ~^data_q;

    // tx is registered, so each state loads the value of the *next* slot at the tick edge.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    data_d  = tx_data;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    idx_d   = '0;
                    tx_d    = data_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            tx_d    = par_bit;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        idx_d = idx_inc;
                        tx_d  = data_q[idx_inc];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    idx_d   = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign tx_done  = done_q;

endmodule
